// File: rtl/mx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mx_pkg
// Description : Shared types and constants for the MX-integer block
//               accumulator: FSM state encoding, IEEE-754 single-precision
//               field constants and the E8M0 scale encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_NORM  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // IEEE-754 binary32 field layout
    localparam int          F32_WIDTH    = 32;
    localparam int          F32_MANT_W   = 23;
    localparam int          F32_EXP_W    = 8;
    localparam logic [7:0]  F32_EXP_ALL1 = 8'hFF;
    localparam logic [31:0] QNAN         = 32'h7FC0_0000;

    // E8M0 shared scale; the all-ones code is reserved for NaN
    localparam int          SCALE_WIDTH  = 8;
    localparam logic [7:0]  SCALE_NAN    = 8'hFF;
    localparam int          EXP_MAX      = 255;

endpackage
`default_nettype wire

// File: rtl/mxint_block_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : mxint_block_accum_if
// Description : Stream bundle between a block producer and the accumulator.
//               Input side : i_valid / o_ready, i_scale, i_elements
//               Output side: o_valid / i_ready, o_float32, o_overflow,
//                            o_underflow
//               slave  modport : the accumulator
//               master modport : the producer/consumer driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface mxint_block_accum_if #(
    parameter int ELEM_WIDTH = 8,
    parameter int LANES      = 4
);
    logic                          i_valid;
    logic                          o_ready;
    logic [7:0]                    i_scale;
    logic [LANES*ELEM_WIDTH-1:0]   i_elements;
    logic                          o_valid;
    logic                          i_ready;
    logic [31:0]                   o_float32;
    logic                          o_overflow;
    logic                          o_underflow;

    modport slave (
        input  i_valid, i_scale, i_elements, i_ready,
        output o_ready, o_valid, o_float32, o_overflow, o_underflow
    );

    modport master (
        output i_valid, i_scale, i_elements, i_ready,
        input  o_ready, o_valid, o_float32, o_overflow, o_underflow
    );
endinterface
`default_nettype wire

// File: rtl/mxint_normalize.sv
`default_nettype none
// ============================================================================
// Module      : mxint_normalize
// Description : Combinational conversion of a signed block sum plus E8M0
//               scale into IEEE-754 single precision. Leading-one detect,
//               left-justify, round-to-nearest-even, special cases.
//   i_acc       : signed block sum, ACC_W bits
//   i_scale     : latched shared scale
//   o_float32   : binary32 result
//   o_overflow  : result saturated to infinity
//   o_underflow : nonzero sum flushed to zero
// Revision    : 1.0 - initial release
// ============================================================================
module mxint_normalize
    import mx_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int ACC_W      = 13
) (
    input  wire [ACC_W-1:0]       i_acc,
    input  wire [SCALE_WIDTH-1:0] i_scale,
    output logic [31:0]           o_float32,
    output logic                  o_overflow,
    output logic                  o_underflow
);
    // Magnitude placed above 24 zero bits so guard/sticky always exist
    localparam int         NW      = ACC_W + F32_MANT_W + 1;
    localparam logic [4:0] TOP_POS = 5'(ACC_W - 1);

    logic                    w_sign;
    logic [ACC_W-1:0]        w_mag;
    logic [4:0]              w_pos;
    logic [NW-1:0]           w_norm;
    logic [F32_MANT_W-1:0]   w_mant;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_round_up;
    logic [F32_MANT_W:0]     w_mant_r;
    logic signed [11:0]      w_exp;
    logic                    w_is_zero;

    assign w_sign = i_acc[ACC_W-1];
    // The most negative sum maps to 2^(ACC_W-1), which still fits unsigned
    assign w_mag  = w_sign ? (~i_acc + 1'b1) : i_acc;

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (w_mag[i]) begin
                w_pos = 5'(i);
            end
        end
    end

    // Leading one lands in the MSB; a zero sum leaves the MSB clear
    assign w_norm     = {w_mag, {(F32_MANT_W + 1){1'b0}}} << (TOP_POS - w_pos);
    assign w_is_zero  = ~w_norm[NW-1];
    assign w_mant     = w_norm[NW-2 -: F32_MANT_W];
    assign w_guard    = w_norm[NW-2-F32_MANT_W];
    assign w_sticky   = |w_norm[NW-3-F32_MANT_W:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_r   = {1'b0, w_mant} + {{F32_MANT_W{1'b0}}, w_round_up};

    // Mantissa carry out leaves the fraction all-zero and bumps the exponent
    assign w_exp = $signed(12'(i_scale) + 12'(w_pos) + 12'(w_mant_r[F32_MANT_W])
                           - 12'(ELEM_WIDTH - 2));

    always_comb begin
        o_float32   = {w_sign, w_exp[F32_EXP_W-1:0], w_mant_r[F32_MANT_W-1:0]};
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        if (i_scale == SCALE_NAN) begin
            o_float32 = QNAN;
        end else if (w_is_zero) begin
            o_float32 = '0;
        end else if (w_exp >= $signed(12'(EXP_MAX))) begin
            o_float32  = {w_sign, F32_EXP_ALL1, {F32_MANT_W{1'b0}}};
            o_overflow = 1'b1;
        end else if (w_exp <= $signed(12'd0)) begin
            o_float32   = {w_sign, {(F32_WIDTH-1){1'b0}}};
            o_underflow = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mxint_block_accum.sv
`default_nettype none
// ============================================================================
// Module      : mxint_block_accum
// Description : Accumulates one MX-integer block (BLOCK_SIZE elements, LANES
//               per beat, one shared E8M0 scale) and emits its sum as an
//               IEEE-754 single with overflow/underflow flags.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : stream bundle (slave side), see mxint_block_accum_if
// Revision    : 1.0 - initial release
// ============================================================================
module mxint_block_accum
    import mx_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int BLOCK_SIZE = 32,
    parameter int LANES      = 4
) (
    input  wire                 i_clk,
    input  wire                 i_rst_n,
    mxint_block_accum_if.slave  bus
);
    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int ACC_W = ELEM_WIDTH + $clog2(BLOCK_SIZE);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SCALE_WIDTH-1:0]    scale_q, scale_d;
    logic                      valid_q, valid_d;
    logic [31:0]               float_q, float_d;
    logic                      ovf_q, ovf_d;
    logic                      udf_q, udf_d;

    logic signed [ACC_W-1:0]   w_lane_sum;
    logic                      w_ready;
    logic                      w_take;
    logic [31:0]               w_norm_float;
    logic                      w_norm_ovf;
    logic                      w_norm_udf;

    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_sum = w_lane_sum
                       + ACC_W'($signed(bus.i_elements[l*ELEM_WIDTH +: ELEM_WIDTH]));
        end
    end

    assign w_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign w_take  = bus.i_valid & w_ready;

    mxint_normalize #(
        .ELEM_WIDTH (ELEM_WIDTH),
        .ACC_W      (ACC_W)
    ) u_normalize (
        .i_acc       (acc_q),
        .i_scale     (scale_q),
        .o_float32   (w_norm_float),
        .o_overflow  (w_norm_ovf),
        .o_underflow (w_norm_udf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        scale_d = scale_q;
        valid_d = valid_q;
        float_d = float_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        case (state_q)
            ST_IDLE: begin
                if (w_take) begin
                    // First beat replaces whatever a previous block left
                    acc_d   = w_lane_sum;
                    scale_d = bus.i_scale;
                    if (BEATS == 1) begin
                        cnt_d   = '0;
                        state_d = ST_NORM;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_take) begin
                    acc_d = acc_q + w_lane_sum;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_NORM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_NORM: begin
                float_d = w_norm_float;
                ovf_d   = w_norm_ovf;
                udf_d   = w_norm_udf;
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            scale_q <= '0;
            valid_q <= 1'b0;
            float_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            scale_q <= scale_d;
            valid_q <= valid_d;
            float_q <= float_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_valid     = valid_q;
    assign bus.o_float32   = float_q;
    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = udf_q;

endmodule
`default_nettype wire

// File: doc/mxint_block_accum.md
MXINT_BLOCK_ACCUM -- requirements
Module: mxint_block_accum

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 8: element width in bits, legal range 4..16.
REQ-002 SHALL have parameter BLOCK_SIZE, default 32: elements per block, a power of 2 in 2..1024.
REQ-003 SHALL have parameter LANES, default 4: elements accepted per beat; LANES divides BLOCK_SIZE.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_valid, input, 1: the input beat is valid.
REQ-007 SHALL have port o_ready, output, 1: the block accepts a beat.
REQ-008 SHALL have port i_scale, input, 8: shared E8M0 scale, sampled on the first beat of a block only.
REQ-009 SHALL have port i_elements, input, LANES*ELEM_WIDTH: two's-complement elements, lane 0 in the LSBs.
REQ-010 SHALL have port o_valid, output, 1: the result is valid.
REQ-011 SHALL have port i_ready, input, 1: the consumer accepts the result.
REQ-012 SHALL have port o_float32, output, 32: IEEE-754 single holding the block sum.
REQ-013 SHALL have port o_overflow, output, 1: the result saturated to infinity.
REQ-014 SHALL have port o_underflow, output, 1: a nonzero sum was flushed to zero.

Function
REQ-015 SHALL define BEATS = BLOCK_SIZE/LANES and ACC_W = ELEM_WIDTH + log2(BLOCK_SIZE); the accumulator is signed ACC_W bits and can never wrap.
REQ-016 SHALL implement FSM states IDLE, ACCUM, NORM and OUT.
- IDLE -> ACCUM on the first handshake (i_valid & o_ready).
- ACCUM -> NORM when beat BEATS-1 is accepted.
- NORM -> OUT unconditionally, after one cycle.
- OUT -> IDLE on i_ready & o_valid.
REQ-017 SHALL drive o_ready high in IDLE and ACCUM and low in NORM and OUT; beats offered while o_ready is low are not consumed.
REQ-018 SHALL, on the first beat, load the accumulator with that beat's lane sum (not add it to the old value) and latch i_scale.
REQ-019 SHALL hold the accumulator and the beat counter while i_valid is low in ACCUM (bubbles are allowed).
REQ-020 SHALL assert o_valid in the cycle after NORM; from the final-beat handshake edge to o_valid high is exactly 2 clock edges.
REQ-021 SHALL hold o_float32, o_overflow and o_underflow stable while o_valid is high and i_ready is low.
REQ-022 SHALL normalise as follows: p = leading-one position of |sum|; E = scale + p - (ELEM_WIDTH-2), computed signed and wide enough not to wrap; the mantissa is the 23 bits below the leading one.
REQ-023 SHALL round p > 23 to nearest, ties to even; a rounding carry out increments E.
REQ-024 SHALL resolve special cases in this priority order:
- scale == 0xFF gives 0x7FC00000, with both flags 0.
- sum == 0 gives 0x00000000, with both flags 0.
- E >= 255 gives signed infinity, with o_overflow = 1.
- E <= 0 gives signed zero, with o_underflow = 1 (no subnormals).
REQ-025 SHALL make the sign bit equal to the accumulator MSB, except for NaN and exact zero.

Reset
REQ-026 SHALL, on i_rst_n low, asynchronously enter IDLE and clear the accumulator, beat counter, latched scale and all outputs.
- Output reset values: o_valid = 0, o_float32 = 0, o_overflow = 0, o_underflow = 0.
- o_ready is high after reset.
REQ-027 SHALL discard any partially accumulated block when reset asserts; the first beat after release starts a new block.

Structure
REQ-028 SHALL place the FSM state enum, FLOAT32 field constants, QNAN = 0x7FC00000, SCALE_WIDTH = 8 and EXP_MAX = 255 in the shared package mx_pkg.
REQ-029 SHALL put the leading-one detection, shift, RNE rounding and special-case resolution in a combinational sub-module mxint_normalize; its output is registered in NORM.

Verification (defaults: 8 beats per block)
REQ-030 SHALL check: scale 127, all elements 0x40 -> 0x42000000, both flags 0, o_valid 2 edges after beat 8.
REQ-031 SHALL check: scale 127, all elements 0x80 -> 0xC2800000.
REQ-032 SHALL check: scale 0xFF with any elements -> 0x7FC00000, o_overflow 0.
REQ-033 SHALL check: scale 0xFE, all elements 0x7F -> 0x7F800000, o_overflow 1.
REQ-034 SHALL check: scale 1, element[0] = 0x01 and the rest 0 -> 0x00000000, o_underflow 1.
REQ-035 SHALL check: i_ready held low 3 cycles in OUT gives a stable output; reset after beat 3, then the 0x40 block -> o_valid 0 during reset, then 0x42000000.
